apb_timer: RTL and testbench



---
 rtl/apb_timer_if.sv | 21 ++
 rtl/apb_timer.sv | 155 +++++++++++++++
 tb/tb_apb_timer.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/apb_timer_if.sv
// APB slave-side bus bundle for apb_timer: request signals from the master,
// completion signals back from the slave.
interface apb_timer_if;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic        PWRITE;
  logic        PENABLE;
  logic        PSEL;
  logic [31:0] PRDATA;
  logic        PREADY;

  modport master (
    output PADDR, PWDATA, PWRITE, PENABLE, PSEL,
    input  PRDATA, PREADY
  );

  modport slave (
    input  PADDR, PWDATA, PWRITE, PENABLE, PSEL,
    output PRDATA, PREADY
  );
endinterface

// File: rtl/apb_timer.sv
// APB timer: prescaled up-counter with auto-reload, UIF flag and one-wait-state bus
// handshake. Define APB_TIMER_IRQ_EN to implement TCR.IE and the level irq output.
module apb_timer #(
  parameter int PSC_W = 16,
  parameter int CNT_W = 32
) (
  input  logic        PCLK,
  input  logic        PRESET,
  apb_timer_if.slave  apb,
  output logic        irq
);

  typedef enum logic {S_IDLE, S_ACK} state_t;

  state_t             state_q, state_d;
  logic               pready_q, pready_d;
  logic [31:0]        prdata_q, prdata_d;
  logic               en_q, en_d;
  logic               ie_q, ie_d;
  logic               uif_q, uif_d;
  logic [PSC_W-1:0]   tpsc_q, tpsc_d;
  logic [PSC_W-1:0]   psc_cnt_q, psc_cnt_d;
  logic [CNT_W-1:0]   tarr_q, tarr_d;
  logic [CNT_W-1:0]   tcnt_q, tcnt_d;

  logic [2:0]         reg_sel;
  logic               wr_commit;
  logic               tick;
  logic               uif_set;
  logic               uif_clr;
  logic [31:0]        rd_mux;
  logic               unused_bits;

  assign reg_sel     = apb.PADDR[4:2];
  assign wr_commit   = (state_q == S_ACK) && apb.PWRITE;
  assign unused_bits = ^{apb.PADDR[31:5], apb.PADDR[1:0]};

  always_comb begin
    rd_mux = '0;
    case (reg_sel)
      3'd0: rd_mux[2:0]       = {ie_q, 1'b0, en_q};
      3'd1: rd_mux[PSC_W-1:0] = tpsc_q;
      3'd2: rd_mux[CNT_W-1:0] = tarr_q;
      3'd3: rd_mux[CNT_W-1:0] = tcnt_q;
      3'd4: rd_mux[0]         = uif_q;
      default: rd_mux = '0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    pready_d  = 1'b0;
    prdata_d  = '0;
    en_d      = en_q;
    ie_d      = ie_q;
    tpsc_d    = tpsc_q;
    tarr_d    = tarr_q;
    psc_cnt_d = psc_cnt_q;
    tcnt_d    = tcnt_q;
    tick      = 1'b0;
    uif_set   = 1'b0;
    uif_clr   = 1'b0;

    // Read data is captured on entry to ACK and dropped back to zero on exit.
    case (state_q)
      S_IDLE: begin
        if (apb.PSEL && apb.PENABLE) begin
          state_d  = S_ACK;
          pready_d = 1'b1;
          prdata_d = rd_mux;
        end
      end
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (en_q) begin
      if (psc_cnt_q == tpsc_q) begin
        psc_cnt_d = '0;
        tick      = 1'b1;
      end else begin
        psc_cnt_d = psc_cnt_q + PSC_W'(1);
      end
    end

    // ">=" so a TARR lowered below the running count still wraps on the next tick.
    if (tick) begin
      if (tcnt_q >= tarr_q) begin
        tcnt_d  = '0;
        uif_set = 1'b1;
      end else begin
        tcnt_d = tcnt_q + CNT_W'(1);
      end
    end

    if (wr_commit) begin
      case (reg_sel)
        3'd0: begin
          en_d = apb.PWDATA[0];
`ifdef APB_TIMER_IRQ_EN
          ie_d = apb.PWDATA[2];
`else
          ie_d = 1'b0;
`endif
          if (apb.PWDATA[1]) begin
            tcnt_d    = '0;
            psc_cnt_d = '0;
          end
        end
        3'd1: tpsc_d  = apb.PWDATA[PSC_W-1:0];
        3'd2: tarr_d  = apb.PWDATA[CNT_W-1:0];
        3'd4: uif_clr = apb.PWDATA[0];
        default: ;
      endcase
    end

    uif_d = uif_set | (uif_q & ~uif_clr);
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q   <= S_IDLE;
      pready_q  <= 1'b0;
      prdata_q  <= '0;
      en_q      <= 1'b0;
      ie_q      <= 1'b0;
      uif_q     <= 1'b0;
      tpsc_q    <= '0;
      tarr_q    <= '0;
      psc_cnt_q <= '0;
      tcnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      pready_q  <= pready_d;
      prdata_q  <= prdata_d;
      en_q      <= en_d;
      ie_q      <= ie_d;
      uif_q     <= uif_d;
      tpsc_q    <= tpsc_d;
      tarr_q    <= tarr_d;
      psc_cnt_q <= psc_cnt_d;
      tcnt_q    <= tcnt_d;
    end
  end

  assign apb.PRDATA = prdata_q;
  assign apb.PREADY = pready_q;

`ifdef APB_TIMER_IRQ_EN
  assign irq = uif_q & ie_q;
`else
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_apb_timer.sv
// Directed bench for apb_timer: register reset values, prescaled counting and wrap,
// UIF clear/set race, TARR shrink, CLR, irq behaviour and reset during ACK.
module tb_apb_timer;

  localparam logic [31:0] BASE   = 32'h1000_6000;
  localparam logic [31:0] A_TCR  = BASE + 32'h00;
  localparam logic [31:0] A_TPSC = BASE + 32'h04;
  localparam logic [31:0] A_TARR = BASE + 32'h08;
  localparam logic [31:0] A_TCNT = BASE + 32'h0C;
  localparam logic [31:0] A_TSR  = BASE + 32'h10;
  localparam logic [31:0] A_RSV  = BASE + 32'h14;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic irq;
  int   n_vec = 0;
  int   n_err = 0;

  apb_timer_if bus();

  apb_timer dut (
    .PCLK   (clk),
    .PRESET (rst),
    .apb    (bus),
    .irq    (irq)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Setup cycle, then PENABLE for two cycles; PREADY must appear only on the second.
  task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata);
    bus.PSEL    = 1'b1;
    bus.PENABLE = 1'b0;
    bus.PWRITE  = wr;
    bus.PADDR   = addr;
    bus.PWDATA  = wdata;
    @(posedge clk); #1;
    bus.PENABLE = 1'b1;
    check_val("pready_first_access", 32'(bus.PREADY), 32'd0);
    @(posedge clk); #1;
    check_val("pready_second_access", 32'(bus.PREADY), 32'd1);
    rdata = bus.PRDATA;
    @(posedge clk); #1;
    bus.PSEL    = 1'b0;
    bus.PENABLE = 1'b0;
    bus.PWRITE  = 1'b0;
    check_val("pready_after", 32'(bus.PREADY), 32'd0);
    $display("apb %s addr=0x%08h wdata=0x%08h rdata=0x%08h", wr ? "WR" : "RD", addr, wdata, rdata);
  endtask

  task automatic apb_wr(input logic [31:0] addr, input logic [31:0] data);
    logic [31:0] dummy;
    apb_xfer(1'b1, addr, data, dummy);
  endtask

  task automatic apb_rd_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] rd;
    apb_xfer(1'b0, addr, 32'h0, rd);
    check_val(tag, rd, exp);
  endtask

  initial begin
    logic [31:0] exp_tcnt [8];
    exp_tcnt = '{32'd0, 32'd1, 32'd1, 32'd2, 32'd3, 32'd4, 32'd4, 32'd0};

    bus.PSEL    = 1'b0;
    bus.PENABLE = 1'b0;
    bus.PWRITE  = 1'b0;
    bus.PADDR   = '0;
    bus.PWDATA  = '0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_pready", 32'(bus.PREADY), 32'd0);
    check_val("rst_prdata", bus.PRDATA, 32'd0);
    check_val("rst_irq", 32'(irq), 32'd0);
    rst = 1'b0;

    apb_rd_chk("rst_tcr",  A_TCR,  32'd0);
    apb_rd_chk("rst_tpsc", A_TPSC, 32'd0);
    apb_rd_chk("rst_tarr", A_TARR, 32'd0);
    apb_rd_chk("rst_tcnt", A_TCNT, 32'd0);
    apb_rd_chk("rst_tsr",  A_TSR,  32'd0);
    check_val("idle_prdata", bus.PRDATA, 32'd0);

    apb_wr(A_RSV, 32'hFFFF_FFFF);
    apb_rd_chk("rsv_reads_zero", A_RSV, 32'd0);

    // Period (3+1)*(4+1) = 20 cycles; back-to-back reads sample every 3 cycles.
    apb_wr(A_TPSC, 32'hFFFF_0003);
    apb_rd_chk("tpsc_width", A_TPSC, 32'd3);
    apb_wr(A_TARR, 32'd4);
    apb_wr(A_TCR, 32'h1);
    for (int i = 0; i < 8; i++) begin
      apb_rd_chk($sformatf("tcnt_run_%0d", i), A_TCNT, exp_tcnt[i]);
    end
    apb_rd_chk("uif_after_wrap", A_TSR, 32'd1);
    apb_wr(A_TSR, 32'h1);
    apb_rd_chk("uif_w1c", A_TSR, 32'd0);
    repeat (4) @(posedge clk);
    #1;
    apb_wr(A_TSR, 32'h1);
    apb_rd_chk("uif_set_wins", A_TSR, 32'd1);

    apb_wr(A_TCR, 32'h0);
    apb_wr(A_TCR, 32'h2);
    apb_wr(A_TSR, 32'h1);
    apb_rd_chk("uif_cleared", A_TSR, 32'd0);
    apb_wr(A_TPSC, 32'd0);
    apb_wr(A_TARR, 32'd20);
    apb_wr(A_TCR, 32'h1);
    repeat (6) @(posedge clk);
    #1;
    apb_wr(A_TCR, 32'h0);
    apb_rd_chk("tcnt_held_9", A_TCNT, 32'd9);
    apb_wr(A_TCNT, 32'h55);
    apb_rd_chk("tcnt_ro", A_TCNT, 32'd9);
    apb_wr(A_TARR, 32'd5);
    apb_wr(A_TCR, 32'h1);
    apb_rd_chk("tarr_shrink_wrap", A_TCNT, 32'd0);
    apb_rd_chk("tarr_shrink_uif", A_TSR, 32'd1);
    apb_wr(A_TCR, 32'h3);
    apb_rd_chk("clr_tcnt", A_TCNT, 32'd1);
    apb_rd_chk("clr_continues", A_TCNT, 32'd4);
    apb_rd_chk("tcr_clr_reads0", A_TCR, 32'd1);

    apb_wr(A_TCR, 32'h0);
    apb_wr(A_TCR, 32'h2);
    apb_wr(A_TSR, 32'h1);
    apb_wr(A_TPSC, 32'd0);
    apb_wr(A_TARR, 32'd2);
    check_val("irq_before_en", 32'(irq), 32'd0);
    apb_wr(A_TCR, 32'h5);
`ifdef APB_TIMER_IRQ_EN
    check_val("irq_en_c0", 32'(irq), 32'd0);
    @(posedge clk); #1;
    check_val("irq_en_c1", 32'(irq), 32'd0);
    @(posedge clk); #1;
    check_val("irq_en_c2", 32'(irq), 32'd0);
    @(posedge clk); #1;
    check_val("irq_en_c3", 32'(irq), 32'd1);
    apb_wr(A_TCR, 32'h4);
    apb_rd_chk("tcr_ie_only", A_TCR, 32'd4);
    check_val("irq_held", 32'(irq), 32'd1);
    apb_wr(A_TSR, 32'h1);
    check_val("irq_cleared", 32'(irq), 32'd0);
`else
    for (int i = 0; i < 4; i++) begin
      check_val($sformatf("irq_tied_c%0d", i), 32'(irq), 32'd0);
      @(posedge clk); #1;
    end
    apb_rd_chk("tcr_no_ie", A_TCR, 32'd1);
    apb_rd_chk("uif_pollable", A_TSR, 32'd1);
    check_val("irq_tied_end", 32'(irq), 32'd0);
`endif

    // Reset arriving in the ACK cycle of a write must cancel the commit.
    bus.PSEL    = 1'b1;
    bus.PENABLE = 1'b0;
    bus.PWRITE  = 1'b1;
    bus.PADDR   = A_TARR;
    bus.PWDATA  = 32'd7;
    @(posedge clk); #1;
    bus.PENABLE = 1'b1;
    @(posedge clk); #1;
    check_val("abort_pready_ack", 32'(bus.PREADY), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.PSEL    = 1'b0;
    bus.PENABLE = 1'b0;
    bus.PWRITE  = 1'b0;
    $display("apb WR addr=0x%08h wdata=0x%08h aborted by reset", A_TARR, 32'd7);
    check_val("abort_pready", 32'(bus.PREADY), 32'd0);
    check_val("abort_prdata", bus.PRDATA, 32'd0);
    @(posedge clk); #1;
    check_val("abort_idle", 32'(bus.PREADY), 32'd0);
    apb_rd_chk("abort_tarr", A_TARR, 32'd0);
    apb_rd_chk("abort_tcr",  A_TCR,  32'd0);
    apb_rd_chk("abort_tcnt", A_TCNT, 32'd0);
    apb_rd_chk("abort_tsr",  A_TSR,  32'd0);
    check_val("abort_irq", 32'(irq), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
